// File: rtl/data_mem.sv
// Word-addressed data memory for the single-cycle datapath: zero-latency loads,
// edge-committed stores, a post-reset clearing sweep, and first-error logging.
module data_mem #(
  parameter int unsigned ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        misalign,
  output logic        out_of_range,
  output logic        err_sticky,
  output logic [31:0] err_addr,
  output logic [15:0] wr_count
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic                err_sticky_q, err_sticky_d;
  logic [31:0]         err_addr_q, err_addr_d;
  logic [15:0]         wr_count_q, wr_count_d;
  logic [31:0]         mem [DEPTH];

  logic [31:0]         offset;
  logic [ADDR_W-1:0]   index;
  logic                req, legal, store_en, sweep_en;

  // BASE is word aligned, so the low offset bits equal the low address bits.
  assign offset       = addr - BASE;
  assign index        = offset[ADDR_W+1:2];
  assign req          = MemRd | MemWr;
  assign misalign     = req & (offset[1:0] != 2'b00);
  assign out_of_range = req & (offset[31:ADDR_W+2] != '0);
  assign busy         = (state_q == INIT) | rst;
  assign legal        = ~misalign & ~out_of_range & ~busy;
  assign store_en     = MemWr & legal;
  assign sweep_en     = (state_q == INIT) & ~rst;

  assign rdata        = (MemRd & legal) ? mem[index] : 32'h0;
  assign err_sticky   = err_sticky_q;
  assign err_addr     = err_addr_q;
  assign wr_count     = wr_count_q;

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    err_sticky_d = err_sticky_q;
    err_addr_d   = err_addr_q;
    wr_count_d   = wr_count_q;
    case (state_q)
      INIT: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) state_d = RUN;
      end
      RUN: begin
        if (req & (misalign | out_of_range) & ~err_sticky_q) begin
          err_sticky_d = 1'b1;
          err_addr_d   = addr;
        end
        if (store_en && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      clr_idx_q    <= '0;
      err_sticky_q <= 1'b0;
      err_addr_q   <= 32'h0;
      wr_count_q   <= 16'h0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      err_sticky_q <= err_sticky_d;
      err_addr_q   <= err_addr_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // Storage carries no reset; the sweep and stores are mutually exclusive.
  always_ff @(posedge clk) begin
    if (sweep_en)      mem[clr_idx_q] <= 32'h0;
    else if (store_en) mem[index]     <= wdata;
  end
endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed scenarios plus random traffic checked each cycle
// against an array-based behavioural model of the memory.
module tb_data_mem;
  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemRd = 1'b0, MemWr = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata, err_addr;
  logic        busy, misalign, out_of_range, err_sticky;
  logic [15:0] wr_count;

  // second instance only exercises the BASE-relative range decode
  logic        rd2 = 1'b0;
  logic [31:0] addr2 = 32'h0;
  logic [31:0] rdata2, err_addr2;
  logic        busy2, mis2, oor2, err2;
  logic [15:0] wrc2;

  always #5 clk = ~clk;

  data_mem #(.ADDR_W(AW), .BASE(BASE)) u_dut (
    .clk(clk), .rst(rst), .MemRd(MemRd), .MemWr(MemWr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .misalign(misalign), .out_of_range(out_of_range),
    .err_sticky(err_sticky), .err_addr(err_addr), .wr_count(wr_count));

  data_mem #(.ADDR_W(AW), .BASE(32'h1000)) u_dut2 (
    .clk(clk), .rst(rst), .MemRd(rd2), .MemWr(1'b0), .addr(addr2), .wdata(32'h0),
    .rdata(rdata2), .busy(busy2), .misalign(mis2), .out_of_range(oor2),
    .err_sticky(err2), .err_addr(err_addr2), .wr_count(wrc2));

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [DEPTH];
  int          m_init_left;
  bit          m_err;
  logic [31:0] m_eaddr;
  int          m_cnt;

  logic [31:0] last_rdata, last_eaddr;
  logic        last_busy, last_mis, last_oor, last_err;
  logic [15:0] last_wrc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check at negedge against the model, then advance the model.
  task automatic cyc(input logic r, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d);
    logic        req, mis, oor, mbusy;
    logic [31:0] off, exp_rd;
    rst = r; MemRd = rd; MemWr = wr; addr = a; wdata = d;
    req    = rd | wr;
    off    = a - BASE;
    mis    = req && (a % 4 != 0);
    oor    = req && (off >= DEPTH * 4);
    mbusy  = r || (m_init_left > 0);
    exp_rd = (rd && !mis && !oor && !mbusy) ? m_mem[off / 4] : 32'h0;
    @(negedge clk);
    chk("busy", busy, mbusy);
    chk("rdata", rdata, exp_rd);
    chk("misalign", misalign, mis);
    chk("out_of_range", out_of_range, oor);
    chk("err_sticky", err_sticky, m_err);
    chk("err_addr", err_addr, m_eaddr);
    chk("wr_count", wr_count, 32'(m_cnt));
    last_rdata = rdata; last_busy = busy; last_mis = misalign; last_oor = out_of_range;
    last_err = err_sticky; last_eaddr = err_addr; last_wrc = wr_count;
    @(posedge clk);
    if (r) begin
      m_init_left = DEPTH; m_err = 0; m_eaddr = 32'h0; m_cnt = 0;
      foreach (m_mem[k]) m_mem[k] = 32'h0;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      if (req && (mis || oor) && !m_err) begin m_err = 1; m_eaddr = a; end
      if (wr && !mis && !oor) begin
        m_mem[off / 4] = d;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    #1;
  endtask

  // Counts busy cycles from the current cycle on, bounded.
  task automatic sweep_len(input string tag);
    int n;
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n = last_busy ? 1 : 0;
    for (int i = 0; i < 40 && last_busy; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (last_busy) n++;
    end
    chk(tag, n, 16);
  endtask

  initial begin
    int          n;
    logic [31:0] a;
    m_init_left = DEPTH; m_err = 0; m_eaddr = 32'h0; m_cnt = 0;
    foreach (m_mem[k]) m_mem[k] = 32'h0;

    // reset state, load request masked
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
    chk("rst_busy", last_busy, 1'b1);
    chk("rst_rdata", last_rdata, 32'h0);

    // sweep with a dropped store in its first cycle
    cyc(1'b0, 1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF);
    n = last_busy ? 1 : 0;
    for (int i = 0; i < 40 && last_busy; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (last_busy) n++;
    end
    chk("sweep_len", n, 16);
    cyc(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
    chk("lw8_dropped", last_rdata, 32'h0);

    // store then load
    cyc(1'b0, 1'b0, 1'b1, 32'h3C, 32'h1234_5678);
    cyc(1'b0, 1'b1, 1'b0, 32'h3C, 32'h0);
    chk("lw3c", last_rdata, 32'h1234_5678);
    chk("wrc_one", last_wrc, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 32'h38, 32'h0);
    chk("lw38", last_rdata, 32'h0);

    // same-cycle read and write
    cyc(1'b0, 1'b0, 1'b1, 32'h10, 32'hA);
    cyc(1'b0, 1'b1, 1'b1, 32'h10, 32'hB);
    chk("rw_old", last_rdata, 32'hA);
    cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    chk("rw_new", last_rdata, 32'hB);

    // error logging keeps the first address
    cyc(1'b0, 1'b0, 1'b1, 32'h6, 32'hFFFF_FFFF);
    chk("mis6", last_mis, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    chk("oor40", last_oor, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 32'h4, 32'h0);
    chk("err_set", last_err, 1'b1);
    chk("err_first", last_eaddr, 32'h6);
    chk("mis_dropped", last_rdata, 32'h0);

    // BASE-relative decode: below BASE wraps out of range
    rd2 = 1'b1; addr2 = 32'h0FFC; #1;
    chk("base_below", oor2, 1'b1);
    addr2 = 32'h1000; #1;
    chk("base_word0", oor2, 1'b0);
    addr2 = 32'h103C; #1;
    chk("base_last", oor2, 1'b0);
    addr2 = 32'h1040; #1;
    chk("base_past", oor2, 1'b1);
    rd2 = 1'b0;

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = $urandom_range(0, 15) * 4;
        6:       a = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
        7:       a = 32'h40 + $urandom_range(0, 255) * 4;
        8:       a = 32'hFFFF_FFFC - $urandom_range(0, 3) * 4;
        default: a = $urandom;
      endcase
      cyc(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), a, $urandom);
    end

    // settle into RUN, make state non-zero, then reset mid-sweep
    for (int i = 0; i < 40 && last_busy; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h0, 32'h55);
    cyc(1'b0, 1'b1, 1'b0, 32'h2, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    sweep_len("midsweep_len");
    chk("midsweep_err", last_err, 1'b0);
    chk("midsweep_eaddr", last_eaddr, 32'h0);
    chk("midsweep_wrc", last_wrc, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("midsweep_clear", last_rdata, 32'h0);

    // saturation of the store counter
    for (int i = 0; i < 65537; i++) cyc(1'b0, 1'b0, 1'b1, 32'((i % 16) * 4), 32'(i));
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrc_sat", last_wrc, 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Word-addressed data memory stage that sits directly downstream of the ALU in the single-cycle datapath.
- Consumes the ALU result as the byte address for lw/sw, and busB as store data.
- Returns load data to the write-back mux.
- After reset it self-clears its storage through a sequential sweep, and it flags and logs illegal accesses.

Parameters:
- ADDR_W, 10, number of word-index bits; DEPTH = 2**ADDR_W words.
- BASE, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- MemRd  input  1  load request for the current cycle.
- MemWr  input  1  store request for the current cycle.
- addr  input  32  byte address (ALU ans).
- wdata  input  32  store data (busB).
- rdata  output  32  load data, combinational.
- busy  output  1  high while the clear sweep runs.
- misalign  output  1  combinational: (MemRd|MemWr) & addr[1:0]!=0.
- out_of_range  output  1  combinational: (MemRd|MemWr) & offset >= DEPTH*4.
- err_sticky  output  1  registered first-error flag.
- err_addr  output  32  registered address of the first illegal access.
- wr_count  output  16  registered count of committed stores, saturating.

Behaviour:
- Reset and synchronicity: one clock domain, clk; reset is synchronous and active-high (rst).
- Address decode:
  - offset = addr - BASE, 32-bit unsigned with wrap; an address below BASE wraps large and is out of range.
  - index = offset[ADDR_W+1:2].
  - legal = !misalign & !out_of_range & !busy.
- State machine:
  - Two states, INIT and RUN.
  - A cycle with rst=1 forces INIT with clr_idx=0, err_sticky=0, err_addr=0, wr_count=0. This applies equally to a reset asserted mid-sweep or mid-run.
  - INIT: each cycle with rst=0 writes mem[clr_idx]=0 and increments clr_idx.
  - When clr_idx == DEPTH-1 is written, the next state is RUN.
  - busy=1 in INIT (including during rst), busy=0 in RUN.
  - Sweep latency is exactly DEPTH cycles after the first cycle with rst=0.
- Loads:
  - rdata = mem[index] when MemRd & legal; otherwise rdata = 32'h0.
  - This covers busy, misaligned, out of range and MemRd=0.
  - Zero-latency read, as the single-cycle core requires.
- Stores:
  - At the rising edge, if MemWr & legal & !rst, then mem[index] <= wdata.
  - The store is dropped silently if it is illegal or busy.
- Simultaneous MemRd & MemWr to the same address: rdata shows the old content during that cycle; the new value is visible from the next cycle.
- Requests while busy: ignored, and not logged as errors; misalign and out_of_range still reflect the raw decode.
- err_sticky / err_addr:
  - On the first cycle in RUN with (MemRd|MemWr) & (misalign|out_of_range) and err_sticky=0, set err_sticky=1 and latch err_addr=addr.
  - Later errors do not overwrite err_addr.
  - Cleared only by rst.
- wr_count:
  - Increments by 1 per committed store.
  - Holds at 16'hFFFF; no wrap.
- Outputs after reset: rdata=0 (MemRd masked by busy), busy=1, err_sticky=0, err_addr=0, wr_count=0; misalign and out_of_range are combinational from the inputs.
- Memory contents: undefined before the first reset; all zero once busy falls.

Test Plan:
- Sweep: ADDR_W=4, rst high 2 cycles then low.
  - busy=1 for exactly 16 cycles after rst falls.
  - A sw to 0x8 with wdata=0xDEAD_BEEF during the sweep is dropped; lw 0x8 after busy falls returns 0.
- Store/load: in RUN, sw 0x3C, 0x1234_5678, then lw 0x3C.
  - rdata=0x1234_5678; wr_count=1.
  - lw 0x38 returns 0.
- Same-cycle read/write: MemRd=MemWr=1 at 0x10 with old value 0xA, wdata=0xB.
  - rdata=0xA that cycle, 0xB the next cycle.
- Errors: sw to 0x6 (misalign=1, store dropped), then lw 0x40 (out_of_range=1).
  - err_sticky=1, err_addr=0x6 retained after the second error.
  - BASE=0x1000 with addr=0xFFC gives out_of_range=1.
- Saturation: force 65537 legal stores → wr_count=0xFFFF.
- Mid-sweep reset: assert rst at sweep cycle 7.
  - Sweep restarts from index 0; busy stays high for a full 16 cycles after rst falls.
  - err_sticky, err_addr and wr_count read 0.
